tc_multi: RTL and testbench
===========================

# tc_multi

Parametrised multi-channel timer/counter peripheral on the CPU bridge; successor to the two-instance single-timer arrangement. It provides `N_CH` independent down-counters in one address window. Each channel runs in one-shot or auto-reload mode. A shared write-1-to-clear pending register supplies per-channel and aggregated interrupt lines for the HWInt vector.

## Interface
Parameters:
- `N_CH`, 2: number of timer channels, 1..8.
- `CNT_W`, 32: counter/preset width, 8..32.
- `AW`, 6: word-address width; must satisfy 2^AW > 4*N_CH.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `addr` in AW: word offset within the block window, i.e. byte address [AW+1:2], already decoded by the bridge.
- `we` in 1: write strobe for the current cycle; full-word writes only.
- `din` in 32: write data.
- `dout` out 32: read data, combinational from `addr`.
- `irq_vec` out N_CH: per-channel interrupt, `pending[i] & IM[i]`.
- `irq` out 1: OR of `irq_vec`.

## Operation
Address map, word offsets:
- Channel i, base 4i:
  - +0 CTRL, R/W.
  - +1 PRESET, R/W.
  - +2 COUNT, read-only.
  - +3 reserved, reads 0.
- 4*N_CH: STATUS. Read returns `pending` zero-extended. Writing 1 to bit i clears pending[i].
- Any other offset reads 0; writes to it are ignored.

CTRL fields:
- [0] EN.
- [2:1] MODE: 00 one-shot, 01 auto-reload, 1x reserved and behaves as one-shot.
- [3] IM, interrupt mask; 1 means enabled.
- Bits [31:4] read 0.

Register widths:
- PRESET stores `din[CNT_W-1:0]`.
- PRESET and COUNT read zero-extended to 32 bits.

Per-channel FSM, states IDLE, LOAD, CNT, INT:
- IDLE: if EN, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If EN=0, go to IDLE with COUNT held.
  - Else if COUNT <= 1, COUNT <= 0 and go to INT.
  - Else COUNT <= COUNT-1.
- INT: set pending[i] on entry to this state (same edge as the CNT->INT transition).
  - One-shot: clear EN and go to IDLE.
  - Auto-reload: go to LOAD if EN is still 1, else IDLE.

Boundary rules:
- PRESET=0 or 1: CNT goes to INT on its first edge.
- A PRESET write while counting takes effect only at the next LOAD.
- A COUNT write is ignored.
- A CTRL write to channel i also clears pending[i].
- A pending set and a clear (STATUS W1C or CTRL write) on the same edge: set wins.
- Clearing IM does not clear pending; re-setting IM re-asserts irq_vec[i] immediately.
- Channels are fully independent. Several channels may set pending on the same edge; all bits are set.

## Timing
- Reset values:
  - All CTRL, PRESET and COUNT registers 0.
  - pending 0.
  - Every FSM in IDLE.
  - irq_vec 0, irq 0.
  - dout follows addr (0 for CTRL, PRESET, COUNT and STATUS after reset).
- Writes commit on the rising edge at which `we` is high. A read of the same register in the following cycle returns the new value.
- Start latency, counting edges from the CTRL write at edge E0:
  - E1: IDLE->LOAD.
  - E2: COUNT=P, state CNT.
  - E2+max(P-1,0)+1: COUNT=0, state INT, pending set.
  - irq_vec is high in the cycle after that edge, when IM=1.
- Auto-reload period: max(P,1)+2 edges between successive pending sets.
- irq_vec and irq are combinational from registered pending/IM; there is no extra latency.
- A reset asserted mid-count returns the channel to reset values on that edge, regardless of state.

## Structure
- Package `tc_pkg` holds:
  - The state enum {IDLE, LOAD, CNT, INT}.
  - Offsets OFF_CTRL=0, OFF_PRESET=1, OFF_COUNT=2, and CH_STRIDE=4.
  - Mode encodings MODE_ONESHOT=2'b00 and MODE_RELOAD=2'b01.
  - The CTRL bit positions.
- Sub-module `tc_channel`, one per channel via a generate loop. It owns CTRL, PRESET, COUNT and the FSM, and outputs a one-cycle `expire` strobe.
- The top level holds address decode, the read mux, and the `pending` register with its set/clear priority.

## Test plan
- Reset then read all offsets -> every register reads 0, irq=0, irq_vec=0.
- Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT=5 two edges later and reaches 0 after 5 more edges. pending[0]=1, irq=1. CTRL reads 0x8 afterwards. STATUS write 0x1 clears irq the next cycle.
- Ch1 PRESET=3, CTRL=0xB (auto-reload) -> pending[1] sets every 5 edges. A W1C on the same edge as a set leaves pending[1]=1.
- Ch0 counting with PRESET=10; after 4 edges write CTRL=0x8 -> state IDLE, COUNT holds 6, no pending. Re-enable -> reloads 10.
- Both channels with PRESET=0 enabled on the same edge -> both pending bits set on the same edge. irq_vec=0b11 with IM set; with IM=0, pending=0b11 while irq_vec=0.
- Reset asserted while Ch0 is in CNT with COUNT=7 -> next cycle COUNT=0, CTRL=0, pending=0, irq=0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and constants for the multi-channel timer/counter block.
// Holds the channel FSM encoding, the per-channel register offsets and the CTRL field positions.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam int OFF_CTRL   = 0;
    localparam int OFF_PRESET = 1;
    localparam int OFF_COUNT  = 2;
    localparam int CH_STRIDE  = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT registers plus the IDLE/LOAD/CNT/INT down-counter FSM.
// expire is a one-cycle strobe that is high during the cycle whose closing edge enters INT.
module tc_channel
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_we,
    input  logic              preset_we,
    input  logic [CTRL_W-1:0] ctrl_din,
    input  logic [CNT_W-1:0]  preset_din,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  preset,
    output logic [CNT_W-1:0]  count,
    output logic              expire
);

    state_t     state;
    logic       en;
    logic       reload;
    logic [1:0] mode;

    assign en     = ctrl[CTRL_EN];
    assign mode   = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    assign reload = (mode == MODE_RELOAD);
    assign expire = (state == CNT) && en && (count <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
        end else begin
            if (preset_we) preset <= preset_din;
            case (state)
                IDLE: if (en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (count <= CNT_W'(1)) begin
                        count <= '0;
                        state <= INT;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                INT: begin
                    // Reserved modes (1x) fall into the one-shot branch.
                    if (reload) begin
                        state <= en ? LOAD : IDLE;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A bus write to CTRL overrides the one-shot auto-clear of EN.
            if (ctrl_we) ctrl <= ctrl_din;
        end
    end

endmodule

// File: rtl/tc_multi.sv
// N_CH-channel timer/counter: address decode, read mux and the shared W1C pending register.
// Pending set from a channel expiring wins over a clear arriving on the same edge.
module tc_multi
    import tc_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int AW    = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   addr,
    input  logic            we,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic [N_CH-1:0] irq_vec,
    output logic            irq
);

    localparam logic [AW-1:0] STATUS_OFF = AW'(CH_STRIDE * N_CH);

    logic [CTRL_W-1:0] ctrl   [N_CH];
    logic [CNT_W-1:0]  preset [N_CH];
    logic [CNT_W-1:0]  count  [N_CH];
    logic [N_CH-1:0]   expire;
    logic [N_CH-1:0]   ctrl_hit;
    logic [N_CH-1:0]   im;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   clr;
    logic              status_we;

    assign status_we = we && (addr == STATUS_OFF);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic preset_we;
        assign ctrl_hit[i] = we && (addr == AW'(CH_STRIDE * i + OFF_CTRL));
        assign preset_we   = we && (addr == AW'(CH_STRIDE * i + OFF_PRESET));
        assign im[i]       = ctrl[i][CTRL_IM];

        tc_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .ctrl_we    (ctrl_hit[i]),
            .preset_we  (preset_we),
            .ctrl_din   (din[CTRL_W-1:0]),
            .preset_din (din[CNT_W-1:0]),
            .ctrl       (ctrl[i]),
            .preset     (preset[i]),
            .count      (count[i]),
            .expire     (expire[i])
        );
    end

    // Any CTRL write to a channel acknowledges that channel's interrupt.
    assign clr = ctrl_hit | (status_we ? din[N_CH-1:0] : '0);

    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~clr) | expire;
    end

    assign irq_vec = pending & im;
    assign irq     = |irq_vec;

    always_comb begin
        dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (addr == AW'(CH_STRIDE * i + OFF_CTRL))   dout = 32'(ctrl[i]);
            if (addr == AW'(CH_STRIDE * i + OFF_PRESET)) dout = 32'(preset[i]);
            if (addr == AW'(CH_STRIDE * i + OFF_COUNT))  dout = 32'(count[i]);
        end
        if (addr == STATUS_OFF) dout = 32'(pending);
    end

endmodule

// File: tb/tb_tc_multi.sv
// Directed/randomised bench for tc_multi; expectations come from the documented timing formulas.
// Inputs change on the falling edge, outputs are sampled shortly after it.
module tb_tc_multi;

    localparam int N_CH   = 2;
    localparam int CNT_W  = 32;
    localparam int AW     = 6;
    localparam int STATUS = 4 * N_CH;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   addr;
    logic            we;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic [N_CH-1:0] irq_vec;
    logic            irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tc_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .din     (din),
        .dout    (dout),
        .irq_vec (irq_vec),
        .irq     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [31:0] req);
        addr = AW'(a);
        #1;
        chk(tag, dout, req);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        addr = AW'(a);
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // COUNT t edges after the enabling CTRL write: loads P at t=2, then counts down to 0.
    function automatic logic [31:0] exp_count(input int p, input int t, input logic [31:0] prev);
        int v;
        if (t < 2) return prev;
        v = p - (t - 2);
        if (v < 0) v = 0;
        return 32'(v);
    endfunction

    // Edges from the enabling write to the first pending set; also the auto-reload period.
    function automatic int period(input int p);
        return ((p > 1) ? p : 1) + 2;
    endfunction

    initial begin
        int p, k, ts, tp;
        int pend, clr;
        logic [31:0] ctrl_v;

        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        idle(3);
        reset = 1'b0;

        // Reset state across the whole window.
        for (int a = 0; a < (1 << AW); a++) begin
            @(negedge clk);
            rd_chk("reset_read", a, 32'h0);
        end
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_irq_vec", 32'(irq_vec), 32'h0);

        // Channel 0 one-shot with IM.
        p = $urandom_range(2, 12);
        wr(1, 32'(p));
        wr(0, 32'h9);
        ts = period(p);
        for (int t = 1; t <= ts + 1; t++) begin
            @(negedge clk);
            rd_chk("os_count", 2, exp_count(p, t, 32'h0));
            rd_chk("os_status", STATUS, (t >= ts) ? 32'h1 : 32'h0);
            chk("os_irq", 32'(irq), (t >= ts) ? 32'h1 : 32'h0);
        end
        rd_chk("os_ctrl_en_cleared", 0, 32'h8);
        wr(STATUS, 32'h1);
        rd_chk("os_w1c_status", STATUS, 32'h0);
        chk("os_w1c_irq", 32'(irq), 32'h0);

        // Channel 1 auto-reload; W1C after each set, and one W1C colliding with a set.
        p  = $urandom_range(1, 6);
        tp = period(p);
        wr(5, 32'(p));
        wr(4, 32'hB);
        pend = 0;
        clr  = 0;
        for (int t = 1; t <= 3 * tp + 1; t++) begin
            @(negedge clk);
            we   = 1'b0;
            pend = (pend & ~clr) | (((t % tp) == 0) ? 1 : 0);
            clr  = 0;
            rd_chk("ar_status", STATUS, 32'(pend << 1));
            chk("ar_irq_vec", 32'(irq_vec), 32'(pend << 1));
            if ((((t % tp) == 0) && (t < 3 * tp)) || (t == 3 * tp - 1)) begin
                din = 32'h2;
                we  = 1'b1;
                clr = 1;
            end
        end
        wr(4, 32'h0);
        rd_chk("ar_ctrl_write_clears", STATUS, 32'h0);
        rd_chk("ar_ctrl_off", 4, 32'h0);

        // Channel 0 stopped mid-count holds COUNT, then reloads a fresh PRESET.
        p = $urandom_range(6, 15);
        k = $urandom_range(1, p - 2);
        wr(1, 32'(p));
        wr(0, 32'h9);
        idle(1 + k);
        wr(0, 32'h8);
        idle(3);
        rd_chk("stop_count_held", 2, 32'(p - k));
        rd_chk("stop_ctrl", 0, 32'h8);
        rd_chk("stop_no_pending", STATUS, 32'h0);
        tp = $urandom_range(6, 15);
        wr(1, 32'(tp));
        wr(0, 32'h9);
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            rd_chk("restart_count", 2, exp_count(tp, t, 32'(p - k)));
        end
        wr(0, 32'h8);
        idle(2);
        rd_chk("restart_no_pending", STATUS, 32'h0);

        // Both channels expire on the same edge, first with IM set, then with IM clear.
        p = $urandom_range(2, 8);
        for (int pass = 0; pass < 2; pass++) begin
            ctrl_v = (pass == 0) ? 32'h9 : 32'h1;
            wr(1, 32'(p));
            wr(5, 32'(p - 1));
            wr(0, ctrl_v);
            wr(4, ctrl_v);
            ts = period(p);
            for (int t = 2; t <= ts; t++) begin
                @(negedge clk);
                rd_chk("dual_status", STATUS, (t >= ts) ? 32'h3 : 32'h0);
                chk("dual_irq_vec", 32'(irq_vec), (t >= ts && pass == 0) ? 32'h3 : 32'h0);
                chk("dual_irq", 32'(irq), (t >= ts && pass == 0) ? 32'h1 : 32'h0);
            end
            if (pass == 1) begin
                wr(0, 32'h8);
                rd_chk("dual_ctrl_clears_p0", STATUS, 32'h2);
                chk("dual_irq_vec_im", 32'(irq_vec), 32'h0);
                rd_chk("dual_ctrl0", 0, 32'h8);
            end
            wr(STATUS, 32'h3);
            rd_chk("dual_w1c", STATUS, 32'h0);
        end

        // Late PRESET write does not disturb the running count; reset mid-count.
        wr(1, 32'd10);
        wr(0, 32'h9);
        idle(2);
        wr(1, 32'd3);
        idle(2);
        rd_chk("late_preset_count", 2, 32'd7);
        rd_chk("late_preset_reg", 1, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_chk("rst_count", 2, 32'h0);
        rd_chk("rst_ctrl", 0, 32'h0);
        rd_chk("rst_preset", 1, 32'h0);
        rd_chk("rst_status", STATUS, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        idle(4);
        rd_chk("rst_stays_idle", 2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
